data_mem_mmio: RTL

- MEM-stage memory subsystem. Consumes the EX/MEM pipeline register outputs (address, store data, MemRead/MemWrite/is_lb) and returns load data combinationally to the MEM/WB register in the same cycle.
- Decodes each address to one of three targets: word-addressed data RAM, a timer/IO peripheral window with LEDs and 7-segment digits, or a free-running systick counter.
- Raises the timer interrupt toward the pipeline control.

---
 rtl/data_mem_mmio_if.sv | 27 ++
 rtl/data_mem_mmio.sv | 130 +++++++++++++
 2 files changed

// File: rtl/data_mem_mmio_if.sv
// rtl/data_mem_mmio_if.sv - EX/MEM stage bus between the pipeline and the memory subsystem
interface data_mem_mmio_if;
  logic [31:0] MEM_Addr;
  logic [31:0] MEM_WriteData;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic        MEM_is_lb;
  logic [31:0] MEM_ReadData;

  modport master (
    output MEM_Addr,
    output MEM_WriteData,
    output MEM_MemRead,
    output MEM_MemWrite,
    output MEM_is_lb,
    input  MEM_ReadData
  );

  modport slave (
    input  MEM_Addr,
    input  MEM_WriteData,
    input  MEM_MemRead,
    input  MEM_MemWrite,
    input  MEM_is_lb,
    output MEM_ReadData
  );
endinterface

// File: rtl/data_mem_mmio.sv
// rtl/data_mem_mmio.sv - MEM-stage data RAM, timer/IO peripheral window and systick
module data_mem_mmio #(
  parameter int          RAM_ADDR_BITS = 8,
  parameter logic [31:0] MMIO_BASE     = 32'h4000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_mmio_if.slave        bus,
  output logic [7:0]            leds,
  output logic [11:0]           digits,
  output logic                  irq
);
  localparam int          RAM_DEPTH = 2 ** RAM_ADDR_BITS;
  localparam logic [29:0] MMIO_WORD = MMIO_BASE[31:2];

  logic [31:0] ram [RAM_DEPTH];

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;

  logic [31:0] th_next;
  logic [31:0] tl_next;
  logic [2:0]  tcon_next;
  logic        ovf_set;

  logic [29:0]              word_addr;
  logic [RAM_ADDR_BITS-1:0] ram_idx;
  logic sel_ram, sel_th, sel_tl, sel_tcon, sel_leds, sel_digits, sel_systick;
  logic wr_ram, wr_th, wr_tl, wr_tcon, wr_leds, wr_digits;

  logic [31:0] word_rd;
  logic [7:0]  byte_rd;

  // Decode looks at the word address only; byte offset matters just for lb.
  assign word_addr   = bus.MEM_Addr[31:2];
  assign ram_idx     = bus.MEM_Addr[RAM_ADDR_BITS+1:2];
  assign sel_ram     = (bus.MEM_Addr[31:RAM_ADDR_BITS+2] == '0);
  assign sel_th      = (word_addr == MMIO_WORD);
  assign sel_tl      = (word_addr == MMIO_WORD + 30'd1);
  assign sel_tcon    = (word_addr == MMIO_WORD + 30'd2);
  assign sel_leds    = (word_addr == MMIO_WORD + 30'd3);
  assign sel_digits  = (word_addr == MMIO_WORD + 30'd4);
  assign sel_systick = (word_addr == MMIO_WORD + 30'd5);

  assign wr_ram    = bus.MEM_MemWrite & sel_ram;
  assign wr_th     = bus.MEM_MemWrite & sel_th;
  assign wr_tl     = bus.MEM_MemWrite & sel_tl;
  assign wr_tcon   = bus.MEM_MemWrite & sel_tcon;
  assign wr_leds   = bus.MEM_MemWrite & sel_leds;
  assign wr_digits = bus.MEM_MemWrite & sel_digits;

  assign irq = tcon[2];

  always_comb begin
    word_rd = '0;
    if (sel_ram)          word_rd = ram[ram_idx];
    else if (sel_th)      word_rd = th;
    else if (sel_tl)      word_rd = tl;
    else if (sel_tcon)    word_rd = {29'd0, tcon};
    else if (sel_leds)    word_rd = {24'd0, leds};
    else if (sel_digits)  word_rd = {20'd0, digits};
    else if (sel_systick) word_rd = systick;
  end

  always_comb begin
    byte_rd = word_rd[7:0];
    case (bus.MEM_Addr[1:0])
      2'd0: byte_rd = word_rd[7:0];
      2'd1: byte_rd = word_rd[15:8];
      2'd2: byte_rd = word_rd[23:16];
      2'd3: byte_rd = word_rd[31:24];
      default: byte_rd = word_rd[7:0];
    endcase
  end

  always_comb begin
    bus.MEM_ReadData = '0;
    if (bus.MEM_MemRead) begin
      if (bus.MEM_is_lb) bus.MEM_ReadData = {{24{byte_rd[7]}}, byte_rd};
      else               bus.MEM_ReadData = word_rd;
    end
  end

  // A CPU write to TL replaces the whole overflow event, including the irq set.
  always_comb begin
    th_next   = th;
    tl_next   = tl;
    tcon_next = tcon;
    ovf_set   = 1'b0;
    if (tcon[0]) begin
      if (tl == 32'hFFFF_FFFF) begin
        tl_next = th;
        ovf_set = tcon[1];
      end else begin
        tl_next = tl + 32'd1;
      end
    end
    if (wr_tl) begin
      tl_next = bus.MEM_WriteData;
      ovf_set = 1'b0;
    end
    if (wr_th) th_next = bus.MEM_WriteData;
    if (wr_tcon) tcon_next = {bus.MEM_WriteData[2] | ovf_set, bus.MEM_WriteData[1:0]};
    else         tcon_next[2] = tcon[2] | ovf_set;
  end

  always_ff @(posedge clk) begin
    if (wr_ram) ram[ram_idx] <= bus.MEM_WriteData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      leds    <= '0;
      digits  <= '0;
      systick <= '0;
    end else begin
      th      <= th_next;
      tl      <= tl_next;
      tcon    <= tcon_next;
      systick <= systick + 32'd1;
      if (wr_leds)   leds   <= bus.MEM_WriteData[7:0];
      if (wr_digits) digits <= bus.MEM_WriteData[11:0];
    end
  end
endmodule
